// File: rtl/mac_tile_sched.sv
// Tile scheduler for the 4-lane 3x3 MAC array. It issues one buffer read per input channel,
// accumulates the returning MAC lanes and queues each finished tile in a 2-entry output FIFO.
module mac_tile_sched #(
    parameter int ACC_W  = 24,
    parameter int CH_W   = 5,
    parameter int TILE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CH_W-1:0]     cfg_num_ch,
    input  logic [TILE_W-1:0]   cfg_num_tile,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [TILE_W-1:0]   rd_tile,
    output logic [CH_W-1:0]     rd_ch,
    output logic                mac_vld_o,
    input  logic                mac_vld_i,
    input  logic [19:0]         mac_out0,
    input  logic [19:0]         mac_out1,
    input  logic [19:0]         mac_out2,
    input  logic [19:0]         mac_out3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*ACC_W-1:0]  out_data,
    output logic [TILE_W-1:0]   out_tile
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [CH_W-1:0]      r_numCh;
    logic [TILE_W-1:0]    r_numTile;
    logic [CH_W-1:0]      r_chCnt;
    logic [TILE_W-1:0]    r_tileCnt;
    logic [CH_W-1:0]      r_retCh;
    logic [TILE_W-1:0]    r_retTile;
    logic [1:0]           r_inflight;
    logic                 r_macVld;
    logic [ACC_W-1:0]     r_acc [4];
    logic [4*ACC_W-1:0]   r_fifoData [2];
    logic [TILE_W-1:0]    r_fifoTile [2];
    logic                 r_wrPtr;
    logic                 r_rdPtr;
    logic [1:0]           r_fifoCnt;

    logic                 w_issue;
    logic                 w_credit;
    logic                 w_lastCh;
    logic                 w_lastTile;
    logic                 w_retVld;
    logic                 w_retLast;
    logic                 w_pop;
    logic [ACC_W-1:0]     w_lane [4];
    logic [ACC_W-1:0]     w_sum [4];
    logic [4*ACC_W-1:0]   w_sumPacked;

    assign w_credit   = ({1'b0, r_fifoCnt} + {1'b0, r_inflight}) < 3'd2;
    assign w_lastCh   = (r_chCnt == r_numCh - CH_W'(1));
    assign w_lastTile = (r_tileCnt == r_numTile - TILE_W'(1));
    assign w_retVld   = mac_vld_i && (r_state != S_IDLE);
    assign w_retLast  = w_retVld && (r_retCh == r_numCh - CH_W'(1));
    assign w_pop      = out_valid && out_ready;

    assign rd_en     = w_issue;
    assign rd_tile   = r_tileCnt;
    assign rd_ch     = r_chCnt;
    assign mac_vld_o = r_macVld;
    assign out_valid = (r_fifoCnt != 2'd0);
    assign out_data  = r_fifoData[r_rdPtr];
    assign out_tile  = r_fifoTile[r_rdPtr];

    // Channel 0 of a tile starts a fresh sum; later channels add to the running accumulators.
    always_comb begin
        w_lane[0] = {{(ACC_W-20){mac_out0[19]}}, mac_out0};
        w_lane[1] = {{(ACC_W-20){mac_out1[19]}}, mac_out1};
        w_lane[2] = {{(ACC_W-20){mac_out2[19]}}, mac_out2};
        w_lane[3] = {{(ACC_W-20){mac_out3[19]}}, mac_out3};
        w_sumPacked = '0;
        for (int k = 0; k < 4; k++) begin
            w_sum[k] = ((r_retCh == '0) ? '0 : r_acc[k]) + w_lane[k];
            w_sumPacked[k*ACC_W +: ACC_W] = w_sum[k];
        end
    end

    // HOLD issues channel 0 in the same cycle the credit check passes, so tiles stay back-to-back.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (cfg_num_ch == '0 || cfg_num_tile == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy    = 1'b1;
                w_issue = 1'b1;
            end
            S_HOLD: begin
                busy    = 1'b1;
                w_issue = w_credit;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_inflight == 2'd0 && r_fifoCnt == 2'd0) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
        if (w_issue) begin
            if (w_lastCh) begin
                w_nextState = w_lastTile ? S_DRAIN : S_HOLD;
            end else begin
                w_nextState = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_numCh    <= '0;
            r_numTile  <= '0;
            r_chCnt    <= '0;
            r_tileCnt  <= '0;
            r_retCh    <= '0;
            r_retTile  <= '0;
            r_inflight <= '0;
            r_macVld   <= 1'b0;
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_fifoCnt  <= '0;
            for (int k = 0; k < 4; k++) r_acc[k] <= '0;
            for (int e = 0; e < 2; e++) begin
                r_fifoData[e] <= '0;
                r_fifoTile[e] <= '0;
            end
        end else begin
            r_state  <= w_nextState;
            r_macVld <= w_issue;
            if (r_state == S_IDLE && start) begin
                r_numCh   <= cfg_num_ch;
                r_numTile <= cfg_num_tile;
                r_chCnt   <= '0;
                r_tileCnt <= '0;
                r_retCh   <= '0;
                r_retTile <= '0;
            end
            if (w_issue) begin
                if (w_lastCh) begin
                    r_chCnt   <= '0;
                    r_tileCnt <= r_tileCnt + TILE_W'(1);
                end else begin
                    r_chCnt <= r_chCnt + CH_W'(1);
                end
            end
            if (w_retVld) begin
                for (int k = 0; k < 4; k++) r_acc[k] <= w_sum[k];
                if (w_retLast) begin
                    r_retCh   <= '0;
                    r_retTile <= r_retTile + TILE_W'(1);
                end else begin
                    r_retCh <= r_retCh + CH_W'(1);
                end
            end
            case ({w_issue && w_lastCh, w_retLast})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: ;
            endcase
            // Credit accounting keeps the FIFO from ever being written while full.
            if (w_retLast) begin
                r_fifoData[r_wrPtr] <= w_sumPacked;
                r_fifoTile[r_wrPtr] <= r_retTile;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_retLast, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + 2'd1;
                2'b01:   r_fifoCnt <= r_fifoCnt - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tile_sched.sv
// Bench for mac_tile_sched: a one-cycle MAC model answers each read, and a scoreboard
// queue of hand-computed tiles is checked by a monitor whenever out_valid is high.
module tb_mac_tile_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   cfg_num_ch = '0;
    logic [15:0]  cfg_num_tile = '0;
    logic         busy, done, rd_en, mac_vld_o, mac_vld_i, out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  rd_tile, out_tile;
    logic [4:0]   rd_ch;
    logic [95:0]  out_data;
    logic [19:0]  modelLane [4] = '{default: '0};
    logic         modelVld = 1'b0;
    logic         injectVld = 1'b0;
    logic [15:0]  capTile = '0;
    logic [4:0]   capCh = '0;
    int           mode = 0;

    typedef struct {
        logic [15:0] tile;
        logic [95:0] data;
    } expEntry_t;
    expEntry_t expQ [$];

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int rdCount = 0;
    int gapCount = 0;
    int lastRdCyc = 0;
    int doneCount = 0;

    mac_tile_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_num_tile(cfg_num_tile),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_tile(rd_tile), .rd_ch(rd_ch),
        .mac_vld_o(mac_vld_o), .mac_vld_i(mac_vld_i),
        .mac_out0(modelLane[0]), .mac_out1(modelLane[1]), .mac_out2(modelLane[2]), .mac_out3(modelLane[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tile(out_tile)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mac_vld_i = modelVld | injectVld;

    function automatic logic [19:0] laneFn(input int m, input int t, input int c, input int k);
        int v;
        case (m)
            0:       v = (k == 0) ? 100 : (k == 1) ? -5 : (k == 2) ? 0 : 7;
            1:       v = 10 * (c + 1) + k;
            2:       v = -524288;
            3:       v = 524287;
            default: v = t * 100 + c * 10 + k;
        endcase
        return v[19:0];
    endfunction

    // MAC model: lanes for the read captured one edge earlier appear one cycle after mac_vld_o.
    always @(posedge clk) begin
        if (rd_en) begin
            capTile <= rd_tile;
            capCh   <= rd_ch;
        end
        modelVld <= mac_vld_o;
        if (mac_vld_o) begin
            for (int k = 0; k < 4; k++) modelLane[k] <= laneFn(mode, int'(capTile), int'(capCh), k);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expVal);
        nCompared++;
        if (act !== expVal) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expVal);
        end
    endtask

    function automatic void pushExp(input int t, input int l0, input int l1, input int l2, input int l3);
        expEntry_t e;
        e.tile = t[15:0];
        e.data = {l3[23:0], l2[23:0], l1[23:0], l0[23:0]};
        expQ.push_back(e);
    endfunction

    // Scoreboard monitor: every presented tile must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 1'b1, 1'b0);
            end else begin
                checkOutput("out_data", out_data, expQ[0].data);
                checkOutput("out_tile", out_tile, expQ[0].tile);
                if (out_ready) void'(expQ.pop_front());
            end
        end
        if (rd_en === 1'b1) begin
            if (rdCount != 0 && lastRdCyc != cyc - 1) gapCount++;
            rdCount++;
            lastRdCyc = cyc;
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic applyStimulus(input int nCh, input int nTile);
        rdCount = 0;
        gapCount = 0;
        doneCount = 0;
        cfg_num_ch = nCh[4:0];
        cfg_num_tile = nTile[15:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int bound, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput(name, seen, 1'b1);
        if (seen) checkOutput({name, "_busy_low"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_rd_en"}, rd_en, 1'b0);
        checkOutput({tag, "_mac_vld_o"}, mac_vld_o, 1'b0);
        checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_rd_tile"}, rd_tile, 16'd0);
        checkOutput({tag, "_rd_ch"}, rd_ch, 5'd0);
        checkOutput({tag, "_out_data"}, out_data, 96'd0);
        checkOutput({tag, "_out_tile"}, out_tile, 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 checkAllZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single channel, single tile with mixed-sign lanes.
        mode = 0;
        pushExp(0, 100, -5, 0, 7);
        applyStimulus(1, 1);
        checkOutput("t1_rd_en_S+1", rd_en, 1'b1);
        checkOutput("t1_busy_S+1", busy, 1'b1);
        waitDone(100, "t1_done");
        checkOutput("t1_rd_count", rdCount, 1);
        checkOutput("t1_done_count", doneCount, 1);
        checkOutput("t1_busy_after", busy, 1'b0);

        // A MAC pulse while idle must not produce a tile.
        injectVld = 1'b1;
        @(posedge clk);
        #1 injectVld = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("idle_vld_ignored", out_valid, 1'b0);

        // Three channels, two tiles: each lane sums to 60+3k.
        mode = 1;
        pushExp(0, 60, 63, 66, 69);
        pushExp(1, 60, 63, 66, 69);
        applyStimulus(3, 2);
        waitDone(100, "t2_done");
        checkOutput("t2_rd_count", rdCount, 6);
        checkOutput("t2_rd_gaps", gapCount, 0);

        // Full-scale sign extension over 16 channels.
        mode = 2;
        pushExp(0, -8388608, -8388608, -8388608, -8388608);
        applyStimulus(16, 1);
        waitDone(100, "t3neg_done");
        checkOutput("t3neg_rd_count", rdCount, 16);
        mode = 3;
        pushExp(0, 8388592, 8388592, 8388592, 8388592);
        applyStimulus(16, 1);
        waitDone(100, "t3pos_done");

        // Backpressure: only tiles 0 and 1 issue until the consumer releases.
        mode = 4;
        for (int t = 0; t < 5; t++) pushExp(t, 200*t + 10, 200*t + 12, 200*t + 14, 200*t + 16);
        out_ready = 1'b0;
        applyStimulus(2, 5);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("bp_rd_count_stalled", rdCount, 4);
        checkOutput("bp_busy_stalled", busy, 1'b1);
        checkOutput("bp_out_valid_stalled", out_valid, 1'b1);
        out_ready = 1'b1;
        waitDone(300, "bp_done");
        checkOutput("bp_rd_count", rdCount, 10);
        checkOutput("bp_queue_empty", expQ.size(), 0);

        // Reset in the middle of ISSUE with results still in flight.
        mode = 1;
        applyStimulus(3, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 checkAllZero("midrst");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 checkOutput("midrst_late_vld_ignored", out_valid, 1'b0);

        // Fresh run after the abort, with a stray start while busy.
        pushExp(0, 60, 63, 66, 69);
        pushExp(1, 60, 63, 66, 69);
        applyStimulus(3, 2);
        cfg_num_ch = 5'd1;
        cfg_num_tile = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(100, "busy_start_done");
        checkOutput("busy_start_rd_count", rdCount, 6);
        checkOutput("busy_start_done_count", doneCount, 1);

        // Zero channels: done immediately, no reads, no output.
        applyStimulus(0, 3);
        checkOutput("zero_ch_done_S+1", done, 1'b1);
        checkOutput("zero_ch_rd_en", rd_en, 1'b0);
        checkOutput("zero_ch_busy", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("zero_ch_rd_count", rdCount, 0);
        checkOutput("zero_ch_done_count", doneCount, 1);
        checkOutput("zero_ch_out_valid", out_valid, 1'b0);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mac_tile_sched.md
# mac_tile_sched

Scheduler and accumulator for the 4-output 3x3 `mac` array. For each output tile it issues one read per input channel to the activation/weight buffers and drives the MAC valid. It accumulates the four per-channel MAC results across all input channels and hands each finished tile to the downstream stage over a valid/ready port. It sits between the conv-layer controller (start/config) and the buffer/MAC/post-processing path.

## Interface
- `ACC_W`, 24: accumulator width per output lane.
- `CH_W`, 5: width of the channel-count config; max 16 channels.
- `TILE_W`, 16: width of the tile-count config and tile index.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `cfg_num_ch` in CH_W: input channels per tile; latched at start.
- `cfg_num_tile` in TILE_W: tiles per run; latched at start.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse at end of run.
- `rd_en` out 1: buffer read strobe; buffer data is valid 1 cycle later.
- `rd_tile` out TILE_W: tile index of the read.
- `rd_ch` out CH_W: channel index of the read; also the weight address.
- `mac_vld_o` out 1: drives `mac.vld_i`; equals `rd_en` delayed 1 cycle.
- `mac_vld_i` in 1: from `mac.vld_mac`.
- `mac_out0`..`mac_out3` in 20 each: MAC lane results, two's complement.
- `out_valid` out 1: head of output FIFO is valid.
- `out_ready` in 1: consumer accepts on `out_valid && out_ready`.
- `out_data` out 4*ACC_W: lane k at bits [k*ACC_W +: ACC_W].
- `out_tile` out TILE_W: tile index of `out_data`.

## Operation
- FSM states IDLE, ISSUE, HOLD, DRAIN, DONE.
  - IDLE: on `start`, latch the config and clear the tile and channel counters.
    - If either config is 0, go to DONE.
    - Otherwise go to ISSUE.
  - ISSUE: assert `rd_en` every cycle with `rd_ch` = 0..num_ch-1 and the current `rd_tile`.
    - After the last channel of a tile, increment `inflight`.
    - If more tiles remain, go to HOLD; otherwise go to DRAIN.
  - HOLD: wait at the tile boundary.
    - Go to ISSUE in the first cycle where `fifo_cnt + inflight < 2`.
    - The check is made in the same cycle, so there is no bubble when space exists.
  - DRAIN: wait for `inflight == 0` and the FIFO empty, then go to DONE.
  - DONE: pulse `done` and return to IDLE.
- Return side, active only while not in IDLE:
  - Each `mac_vld_i` pulse sign-extends the four lanes to ACC_W.
  - Channel 0 of a tile overwrites the accumulators; later channels add to them.
  - A return channel counter wraps at num_ch.
  - On the last channel, write the summed lanes and the return tile index into a 2-entry FIFO, and decrement `inflight`.
  - `mac_vld_i` in IDLE is ignored.
- Width: 20b + log2(16) = 24b. No overflow is possible at the defaults; wrap is modular with no saturation.
- A `start` that arrives while not in IDLE is ignored.
- Simultaneous events:
  - FIFO write and FIFO pop in the same cycle leave `fifo_cnt` unchanged.
  - An `inflight` increment and decrement in the same cycle leave it unchanged.

## Timing
- Reset values:
  - `busy`, `done`, `rd_en`, `mac_vld_o`, `out_valid` are 0.
  - `rd_tile`, `rd_ch`, `out_data`, `out_tile` are 0.
  - FSM is in IDLE; FIFO, counters and accumulators are cleared.
- `rst` mid-run aborts in the same edge. MAC results still in flight afterwards are dropped because the FSM is in IDLE.
- `start` at cycle S: `rd_en` is first high at S+1 and `busy` is high from S+1.
- Throughput is one channel per cycle. Back-to-back tiles issue with no gap while the credit check passes.
- Last `mac_vld_i` of a tile at cycle R gives `out_valid` at R+1.
- `done` is high for exactly one cycle, the cycle after DRAIN sees the empty condition; `busy` falls in that same cycle.
- `out_data` and `out_tile` stay stable while `out_valid && !out_ready`.

## Test plan
- num_ch=1, num_tile=1, lanes 100/-5/0/7:
  - Expect one `rd_en` at S+1.
  - Expect `out_data` lanes 100/-5/0/7 and `out_tile`=0.
  - Expect `done` once and `busy` low afterwards.
- num_ch=3, num_tile=2, each channel returns lane k = 10*(ch+1)+k:
  - Expect tile 0 lanes 60/63/66/69, then tile 1 with the same values.
  - Expect 6 contiguous `rd_en` cycles.
- Full-scale sign extension, num_ch=16:
  - All lanes -524288 gives -8388608 (0x800000).
  - All lanes 524287 gives 8388592.
- Backpressure, num_ch=2, num_tile=5, `out_ready`=0 until idle:
  - Issue stops after tile 1 (FIFO holds 2).
  - Releasing `out_ready` completes all 5 tiles in order 0..4 with no loss or duplication.
- `rst` asserted mid-ISSUE with results in flight:
  - All outputs go to 0 the next cycle.
  - Late `mac_vld_i` pulses are ignored.
  - A fresh run then gives correct results.
- Degenerate and protocol cases:
  - num_ch=0: `done` at S+1 with no `rd_en` and no `out_valid`.
  - A `start` pulse while `busy` is ignored.
